// File: rtl/timer_control.sv
// rtl/timer_control.sv - countdown timer sequencer with prescaler, auto-reload, hold and expiry flags
module timer_control #(
    parameter int W = 8,
    parameter int P = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] value,
    input  logic [P-1:0] prescale,
    input  logic         periodic,
    input  logic         start,
    input  logic         stop,
    input  logic         hold,
    input  logic         ack,
    output logic [W-1:0] count,
    output logic         busy,
    output logic         expire,
    output logic         pending,
    output logic         overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [W-1:0] CNT_ONE = W'(1);
    localparam logic [P-1:0] PC_ONE  = P'(1);

    state_t       state, state_n;
    logic [W-1:0] count_n, rv, rv_n;
    logic [P-1:0] pc, pc_n, rs, rs_n;
    logic         rp, rp_n;
    logic         expire_n, pending_n, overrun_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            pc      <= '0;
            rv      <= '0;
            rs      <= '0;
            rp      <= 1'b0;
            expire  <= 1'b0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            pc      <= pc_n;
            rv      <= rv_n;
            rs      <= rs_n;
            rp      <= rp_n;
            expire  <= expire_n;
            pending <= pending_n;
            overrun <= overrun_n;
        end
    end

    always_comb begin
        state_n  = state;
        count_n  = count;
        pc_n     = pc;
        rv_n     = rv;
        rs_n     = rs;
        rp_n     = rp;
        expire_n = 1'b0;
        if (start) begin
            rv_n    = value;
            rs_n    = prescale;
            rp_n    = periodic;
            pc_n    = prescale;
            count_n = value;
            if (value != '0) begin
                state_n = RUN;
            end else begin
                state_n  = IDLE;
                expire_n = 1'b1;
            end
        end else if (stop) begin
            state_n = IDLE;
            count_n = '0;
            pc_n    = '0;
        end else if (state == RUN && hold) begin
            state_n = HOLD;
        end else if (state == RUN || state == HOLD) begin
            // Leaving HOLD counts as a normal run edge so a hold of H cycles costs exactly H.
            if (!hold) begin
                state_n = RUN;
                if (pc != '0) begin
                    pc_n = pc - PC_ONE;
                end else begin
                    pc_n = rs;
                    if (count > CNT_ONE) begin
                        count_n = count - CNT_ONE;
                    end else begin
                        expire_n = 1'b1;
                        if (rp) begin
                            count_n = rv;
                        end else begin
                            count_n = '0;
                            state_n = IDLE;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        pending_n = pending;
        overrun_n = overrun;
        if (expire_n) begin
            pending_n = 1'b1;
            if (ack)
                overrun_n = 1'b0;
            else if (pending)
                overrun_n = 1'b1;
        end else if (ack) begin
            pending_n = 1'b0;
            overrun_n = 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_timer_control.sv
// tb/tb_timer_control.sv - directed self-checking bench for timer_control
module tb_timer_control;

    logic       clock = 1'b0;
    logic       reset, periodic, start, stop, hold, ack;
    logic [7:0] value, prescale;
    logic [7:0] count;
    logic       busy, expire, pending, overrun;
    int         n_cmp = 0;
    int         n_err = 0;

    timer_control #(.W(8), .P(8)) dut (
        .clock(clock), .reset(reset), .value(value), .prescale(prescale),
        .periodic(periodic), .start(start), .stop(stop), .hold(hold), .ack(ack),
        .count(count), .busy(busy), .expire(expire), .pending(pending), .overrun(overrun)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {count, busy, expire, pending, overrun}
    function automatic logic [11:0] outs();
        return {count, busy, expire, pending, overrun};
    endfunction

    function automatic logic [11:0] exp_o(input logic [7:0] c, input logic b, e, p, o);
        return {c, b, e, p, o};
    endfunction

    task automatic go(input logic [7:0] v, input logic [7:0] s, input logic per);
        value = v; prescale = s; periodic = per; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic clear_flags();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; periodic = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0; ack = 1'b0;
        value = 8'd0; prescale = 8'd0;
        step(); step();
        reset = 1'b0;
        chk("reset_state", outs(), exp_o(8'd0, 0, 0, 0, 0));

        // one-shot V=3 S=0
        go(8'd3, 8'd0, 1'b0);
        chk("os_e0", outs(), exp_o(8'd3, 1, 0, 0, 0));
        step(); chk("os_e1", outs(), exp_o(8'd2, 1, 0, 0, 0));
        step(); chk("os_e2", outs(), exp_o(8'd1, 1, 0, 0, 0));
        step(); chk("os_e3", outs(), exp_o(8'd0, 0, 1, 1, 0));
        step(); chk("os_after", outs(), exp_o(8'd0, 0, 0, 1, 0));
        clear_flags();
        chk("os_ack", outs(), exp_o(8'd0, 0, 0, 0, 0));

        // periodic V=2 S=1: expire at edges 4, 8, 12
        go(8'd2, 8'd1, 1'b1);
        chk("per_e0", outs(), exp_o(8'd2, 1, 0, 0, 0));
        for (int e = 1; e <= 12; e++) begin
            step();
            chk($sformatf("per_cnt_e%0d", e), {24'd0, count},
                ((e / 2) % 2 == 0) ? 32'd2 : 32'd1);
            chk($sformatf("per_exp_e%0d", e), {31'd0, expire}, (e % 4 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("per_busy_e%0d", e), {31'd0, busy}, 32'd1);
        end
        chk("per_flags", {30'd0, pending, overrun}, 32'd3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("per_stop", outs(), exp_o(8'd0, 0, 0, 1, 1));
        for (int e = 0; e < 6; e++) begin
            step();
            chk("per_quiet", outs(), exp_o(8'd0, 0, 0, 1, 1));
        end
        clear_flags();
        chk("per_ack", outs(), exp_o(8'd0, 0, 0, 0, 0));

        // hold for 5 cycles after edge 1 moves expiry to edge 8
        go(8'd3, 8'd0, 1'b0);
        step(); chk("hold_e1", outs(), exp_o(8'd2, 1, 0, 0, 0));
        hold = 1'b1;
        for (int e = 2; e <= 6; e++) begin
            step();
            chk($sformatf("hold_e%0d", e), outs(), exp_o(8'd2, 1, 0, 0, 0));
        end
        hold = 1'b0;
        step(); chk("hold_e7", outs(), exp_o(8'd1, 1, 0, 0, 0));
        step(); chk("hold_e8", outs(), exp_o(8'd0, 0, 1, 1, 0));
        clear_flags();

        // start with V=0, periodic requested but treated as one-shot
        go(8'd0, 8'd3, 1'b1);
        chk("zero_start", outs(), exp_o(8'd0, 0, 1, 1, 0));
        step(); chk("zero_after", outs(), exp_o(8'd0, 0, 0, 1, 0));
        clear_flags();

        // restart: V=5 then V=2 at edge 2
        go(8'd5, 8'd0, 1'b0);
        chk("rst_e0", outs(), exp_o(8'd5, 1, 0, 0, 0));
        step(); chk("rst_e1", outs(), exp_o(8'd4, 1, 0, 0, 0));
        go(8'd2, 8'd0, 1'b0);
        chk("rst_e2", outs(), exp_o(8'd2, 1, 0, 0, 0));
        step(); chk("rst_e3", outs(), exp_o(8'd1, 1, 0, 0, 0));
        step(); chk("rst_e4", outs(), exp_o(8'd0, 0, 1, 1, 0));
        clear_flags();

        // flags: periodic V=1 S=0 expires every edge
        go(8'd1, 8'd0, 1'b1);
        chk("flg_e0", outs(), exp_o(8'd1, 1, 0, 0, 0));
        step(); chk("flg_e1", outs(), exp_o(8'd1, 1, 1, 1, 0));
        step(); chk("flg_e2", outs(), exp_o(8'd1, 1, 1, 1, 1));
        ack = 1'b1;
        step(); chk("flg_ack_exp", outs(), exp_o(8'd1, 1, 1, 1, 0));
        stop = 1'b1;
        step(); chk("flg_ack_quiet", outs(), exp_o(8'd0, 0, 0, 0, 0));
        stop = 1'b0; ack = 1'b0;

        // maximum prescale: V=1 S=255 expires at edge 256
        go(8'd1, 8'd255, 1'b0);
        for (int e = 1; e <= 255; e++) begin
            step();
            chk("maxps_wait", outs(), exp_o(8'd1, 1, 0, 0, 0));
        end
        step(); chk("maxps_e256", outs(), exp_o(8'd0, 0, 1, 1, 0));
        clear_flags();

        // maximum value, periodic
        go(8'd255, 8'd0, 1'b1);
        chk("maxv_e0", outs(), exp_o(8'd255, 1, 0, 0, 0));
        step(); chk("maxv_e1", outs(), exp_o(8'd254, 1, 0, 0, 0));

        // reset mid-run
        go(8'd4, 8'd0, 1'b0);
        step(); chk("rmid_e1", outs(), exp_o(8'd3, 1, 0, 0, 0));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rmid_e2", outs(), exp_o(8'd0, 0, 0, 0, 0));
        for (int e = 0; e < 6; e++) begin
            step();
            chk("rmid_quiet", outs(), exp_o(8'd0, 0, 0, 0, 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
